// File: rtl/io_handshake_ctrl_pkg.sv
// Shared processor-control definitions used by the I/O handshake sequencer.
package io_handshake_ctrl_pkg;

    localparam logic [5:0] OP_IN  = 6'b111100;
    localparam logic [5:0] OP_OUT = 6'b111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PRESSED = 2'd2
    } hs_state_t;

    // True for the two operator-paced I/O opcodes.
    function automatic logic is_io_op(input logic [5:0] opcode);
        return (opcode == OP_IN) || (opcode == OP_OUT);
    endfunction

endpackage

// File: rtl/io_handshake_ctrl_button_debouncer.sv
// Push-button synchroniser and debouncer producing one-cycle rise/fall events.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             btn_s;
    logic             btn_db;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYC cycles;
    // the edge event is registered on the same edge the level flips.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_db <= btn_s;
                cnt    <= '0;
                rise   <= btn_s;
                fall   <= ~btn_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_handshake_ctrl.sv
// I/O handshake sequencer: arms on start, toggles subiu on press and desceu on release.
module io_handshake_ctrl
    import io_handshake_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_input,
    input  logic              btn,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] acc_data,
    output logic              subiu,
    output logic              desceu,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] disp_data
);

    hs_state_t state_q;
    hs_state_t state_d;
    logic      mode;
    logic      rise;
    logic      fall;
    logic      accept_start;
    logic      take_press;
    logic      take_release;

    button_debouncer #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debouncer (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .rise (rise),
        .fall (fall)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; events outside their own state are dropped here.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        take_press   = 1'b0;
        take_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    take_press = 1'b1;
                    state_d    = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    take_release = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Mode, handshake flags, done pulse and held data words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= 1'b0;
            subiu     <= 1'b0;
            desceu    <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            disp_data <= '0;
        end else begin
            done <= take_release;
            if (accept_start) begin
                mode <= is_input;
                if (!is_input) begin
                    disp_data <= acc_data;
                end
            end
            if (take_press) begin
                subiu <= ~subiu;
                if (mode) begin
                    rd_data <= sw_data;
                end
            end
            if (take_release) begin
                desceu <= ~desceu;
            end
        end
    end

    assign busy = (state_q == ARMED) || (state_q == PRESSED);

endmodule

// File: tb/tb_io_handshake_ctrl.sv
// Scoreboard bench for io_handshake_ctrl with DEBOUNCE_CYC = 4.
module tb_io_handshake_ctrl;

    localparam int unsigned DW  = 32;
    localparam int unsigned DC  = 4;
    // Raw drive (just after edge c) to flag toggle at edge c + DC + 3.
    localparam int unsigned LAT = DC + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          is_input;
    logic          btn;
    logic [DW-1:0] sw_data;
    logic [DW-1:0] acc_data;
    logic          subiu;
    logic          desceu;
    logic          busy;
    logic          done;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] disp_data;

    io_handshake_ctrl #(
        .DATA_W      (DW),
        .DEBOUNCE_CYC(DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .is_input (is_input),
        .btn      (btn),
        .sw_data  (sw_data),
        .acc_data (acc_data),
        .subiu    (subiu),
        .desceu   (desceu),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rel;
        int unsigned   cyc;
        logic          subiu;
        logic          desceu;
        logic          done;
        logic [DW-1:0] rd;
        logic [DW-1:0] disp;
    } ev_t;

    ev_t         expq[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;

    logic          exp_subiu  = 1'b0;
    logic          exp_desceu = 1'b0;
    logic          exp_in     = 1'b0;
    logic [DW-1:0] exp_rd     = '0;
    logic [DW-1:0] exp_disp   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic in, input logic [DW-1:0] acc, input logic [DW-1:0] sw);
        start    = 1'b1;
        is_input = in;
        acc_data = acc;
        sw_data  = sw;
        exp_in   = in;
        if (!in) exp_disp = acc;
        tick(1);
        start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_disp", disp_data, exp_disp);
    endtask

    task automatic press();
        ev_t e;
        btn       = 1'b1;
        exp_subiu = ~exp_subiu;
        if (exp_in) exp_rd = sw_data;
        e = '{rel: 1'b0, cyc: cyc + LAT, subiu: exp_subiu, desceu: exp_desceu,
              done: 1'b0, rd: exp_rd, disp: exp_disp};
        expq.push_back(e);
    endtask

    task automatic release_btn();
        ev_t e;
        btn        = 1'b0;
        exp_desceu = ~exp_desceu;
        e = '{rel: 1'b1, cyc: cyc + LAT, subiu: exp_subiu, desceu: exp_desceu,
              done: 1'b1, rd: exp_rd, disp: exp_disp};
        expq.push_back(e);
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_subiu"}, {31'd0, subiu}, {31'd0, exp_subiu});
        check({name, "_desceu"}, {31'd0, desceu}, {31'd0, exp_desceu});
    endtask

    // Monitor: any flag change or done pulse is an event matched against the queue.
    logic prev_s, prev_d;
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_s = subiu;
            prev_d = desceu;
        end else if (subiu !== prev_s || desceu !== prev_d || done !== 1'b0) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got subiu=%b desceu=%b done=%b expected no event (cycle %0d)",
                         subiu, desceu, done, cyc);
            end else begin
                e = expq.pop_front();
                check(e.rel ? "rel_cycle" : "press_cycle", cyc, e.cyc);
                check("ev_subiu", {31'd0, subiu}, {31'd0, e.subiu});
                check("ev_desceu", {31'd0, desceu}, {31'd0, e.desceu});
                check("ev_done", {31'd0, done}, {31'd0, e.done});
                check("ev_rd_data", rd_data, e.rd);
                check("ev_disp_data", disp_data, e.disp);
            end
            prev_s = subiu;
            prev_d = desceu;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        is_input = 1'b0;
        btn      = 1'b0;
        sw_data  = '0;
        acc_data = '0;
        tick(3);
        rst_n = 1'b1;
        tick(10);

        // Reset state.
        check_idle("reset");
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_rd", rd_data, 32'd0);
        check("reset_disp", disp_data, 32'd0);

        // IN: 8-cycle press then release.
        do_start(1'b1, 32'h0, 32'h0000_00A5);
        tick(3);
        press();
        tick(8);
        release_btn();
        tick(10);
        check_idle("in_end");
        check("in_rd", rd_data, 32'h0000_00A5);

        // OUT with ignored starts in ARMED and PRESSED.
        do_start(1'b0, 32'hDEAD_BEEF, 32'h1111_1111);
        tick(3);
        start = 1'b1; is_input = 1'b1; acc_data = 32'h1234_5678;
        tick(1);
        start = 1'b0;
        check("armed_ign_disp", disp_data, 32'hDEAD_BEEF);
        check("armed_ign_busy", {31'd0, busy}, 32'd1);
        tick(2);
        press();
        tick(8);
        start = 1'b1; is_input = 1'b1; acc_data = 32'hCAFE_F00D;
        tick(1);
        start = 1'b0;
        check("pressed_ign_disp", disp_data, 32'hDEAD_BEEF);
        check("pressed_ign_busy", {31'd0, busy}, 32'd1);
        release_btn();
        tick(10);
        check_idle("out_end");
        check("out_rd_kept", rd_data, 32'h0000_00A5);

        // Bounce: five 3-cycle glitches in ARMED, then one stable press.
        do_start(1'b1, 32'h0, 32'h0000_0077);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            tick(3);
            btn = 1'b0;
            tick(3);
        end
        tick(5);
        check("bounce_no_toggle", {31'd0, subiu}, {31'd0, exp_subiu});
        press();
        tick(8);
        release_btn();
        tick(10);
        check_idle("bounce_end");

        // Button pressed in IDLE and held through start: needs release and re-press.
        btn = 1'b1;
        tick(12);
        check_idle("idle_press");
        do_start(1'b0, 32'h0BAD_F00D, 32'h2222_2222);
        btn = 1'b0;
        tick(12);
        check("held_still_armed", {31'd0, busy}, 32'd1);
        press();
        tick(8);
        release_btn();
        tick(10);
        check_idle("held_end");

        // Reset in PRESSED.
        do_start(1'b1, 32'h0, 32'h0000_003C);
        tick(2);
        press();
        tick(9);
        rst_n = 1'b0;
        #1;
        exp_subiu = 1'b0; exp_desceu = 1'b0; exp_rd = '0; exp_disp = '0; exp_in = 1'b0;
        check_idle("midrst");
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_rd", rd_data, 32'd0);
        check("midrst_disp", disp_data, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        btn = 1'b0;
        tick(12);
        check_idle("post_rst");

        // Full IN after reset, then back-to-back OUT start in the cycle after done.
        do_start(1'b1, 32'h0, 32'h0000_005A);
        tick(2);
        press();
        tick(8);
        release_btn();
        tick(LAT);
        do_start(1'b0, 32'hFEED_FACE, 32'h3333_3333);
        tick(2);
        press();
        tick(8);
        release_btn();
        tick(10);
        check_idle("b2b_end");
        check("b2b_rd", rd_data, 32'h0000_005A);
        check("b2b_disp", disp_data, 32'hFEED_FACE);

        check("queue_drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
